// File: rtl/board_text_serializer_pkg.sv
// Shared cell codes, ASCII constants and FSM encoding
// for the board text serializer.
package board_text_serializer_pkg;

  localparam int CELL_W = 2;

  localparam logic [CELL_W-1:0] CELL_BLANK = 2'd0;
  localparam logic [CELL_W-1:0] CELL_X     = 2'd1;
  localparam logic [CELL_W-1:0] CELL_O     = 2'd2;
  localparam logic [CELL_W-1:0] CELL_RSVD  = 2'd3;

  localparam logic [7:0] CHR_NL    = 8'h0A;
  localparam logic [7:0] CHR_SP    = 8'h20;
  localparam logic [7:0] CHR_BLANK = 8'h5F;
  localparam logic [7:0] CHR_X     = 8'h58;
  localparam logic [7:0] CHR_O     = 8'h4F;
  localparam logic [7:0] CHR_RSVD  = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_LEAD,
    ST_CELL,
    ST_SEP,
    ST_EOL,
    ST_FIN
  } state_t;

endpackage

// File: rtl/cell_char_lut.sv
// Combinational cell code to ASCII character map,
// shared with the legacy printer path.
module cell_char_lut
  import board_text_serializer_pkg::*;
(
  input  logic [CELL_W-1:0] code,
  output logic [7:0]        chr
);

  always_comb begin
    unique case (code)
      CELL_X:    chr = CHR_X;
      CELL_O:    chr = CHR_O;
      CELL_RSVD: chr = CHR_RSVD;
      default:   chr = CHR_BLANK;
    endcase
  end

endmodule

// File: rtl/board_text_serializer.sv
// Snapshots a ROWS x COLS board and streams it as ASCII
// text over a valid/ready byte interface.
module board_text_serializer
  import board_text_serializer_pkg::*;
#(
  parameter int ROWS        = 3,
  parameter int COLS        = 3,
  parameter int SPACED      = 1,
  parameter int CHANGE_ONLY = 0,
  parameter int CNT_W       = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [CELL_W*ROWS*COLS-1:0] board,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        skipped,
  output logic [7:0]                  char_data,
  output logic                        char_valid,
  input  logic                        char_ready,
  output logic [CNT_W-1:0]            frame_count
);

  localparam int N    = ROWS * COLS;
  localparam int RC   = (ROWS > COLS) ? ROWS : COLS;
  localparam int RC_W = $clog2(RC + 1);

  state_t state, state_n;

  logic [CELL_W*N-1:0] snap, last_snap;
  logic                last_valid;
  logic                skip_q, skip_n;
  logic [RC_W-1:0]     row, col, row_n, col_n;
  logic                acc;
  logic                valid_n;
  logic [7:0]          data_n;
  logic [7:0]          chr;
  logic [CELL_W-1:0]   code;
  int                  idx;

  assign acc     = char_valid && char_ready;
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_FIN);
  assign skipped = done && skip_q;

  always_comb begin
    state_n = state;
    row_n   = row;
    col_n   = col;
    skip_n  = skip_q;
    case (state)
      ST_IDLE: begin
        if (start) state_n = ST_CHECK;
      end
      ST_CHECK: begin
        skip_n  = (CHANGE_ONLY != 0) && last_valid
                  && (snap == last_snap);
        state_n = skip_n ? ST_FIN : ST_LEAD;
      end
      ST_LEAD: begin
        if (acc) begin
          row_n   = '0;
          col_n   = '0;
          state_n = ST_CELL;
        end
      end
      ST_CELL: begin
        if (acc) begin
          if (col == RC_W'(COLS - 1)) state_n = ST_EOL;
          else if (SPACED != 0) state_n = ST_SEP;
          else col_n = col + RC_W'(1);
        end
      end
      ST_SEP: begin
        if (acc) begin
          col_n   = col + RC_W'(1);
          state_n = ST_CELL;
        end
      end
      ST_EOL: begin
        if (acc) begin
          if (row == RC_W'(ROWS - 1)) begin
            state_n = ST_FIN;
          end else begin
            row_n   = row + RC_W'(1);
            col_n   = '0;
            state_n = ST_CELL;
          end
        end
      end
      ST_FIN:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Byte for the state being entered, so char_valid/char_data
  // are registered and hold unchanged while stalled.
  always_comb begin
    idx  = int'(row_n) * COLS + int'(col_n);
    code = CELL_BLANK;
    if (idx < N) code = snap[idx*CELL_W +: CELL_W];
  end

  cell_char_lut u_lut (
    .code (code),
    .chr  (chr)
  );

  always_comb begin
    valid_n = 1'b0;
    data_n  = 8'h00;
    case (state_n)
      ST_LEAD: begin valid_n = 1'b1; data_n = CHR_NL; end
      ST_EOL:  begin valid_n = 1'b1; data_n = CHR_NL; end
      ST_SEP:  begin valid_n = 1'b1; data_n = CHR_SP; end
      ST_CELL: begin valid_n = 1'b1; data_n = chr;    end
      default: begin valid_n = 1'b0; data_n = 8'h00;  end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      row         <= '0;
      col         <= '0;
      skip_q      <= 1'b0;
      char_valid  <= 1'b0;
      char_data   <= 8'h00;
      snap        <= '0;
      last_snap   <= '0;
      last_valid  <= 1'b0;
      frame_count <= '0;
    end else begin
      state      <= state_n;
      row        <= row_n;
      col        <= col_n;
      skip_q     <= skip_n;
      char_valid <= valid_n;
      char_data  <= data_n;
      if (state == ST_IDLE && start) snap <= board;
      if (state == ST_FIN && !skip_q) begin
        last_snap   <= snap;
        last_valid  <= 1'b1;
        frame_count <= frame_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_board_text_serializer.sv
// Scoreboard bench: a 3x3 spaced change-only instance
// and a 2x4 packed instance.
module tb_board_text_serializer;
  import board_text_serializer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic [17:0] board_a;
  logic        start_a, a_busy, a_done, a_skipped;
  logic [7:0]  a_data;
  logic        a_valid, a_ready;
  logic [15:0] a_fc;

  logic [15:0] board_b;
  logic        start_b, b_busy, b_done, b_skipped;
  logic [7:0]  b_data;
  logic        b_valid, b_ready;
  logic [15:0] b_fc;

  board_text_serializer #(
    .ROWS(3), .COLS(3), .SPACED(1),
    .CHANGE_ONLY(1), .CNT_W(16)
  ) u_a (
    .clock(clk), .reset(rst), .board(board_a),
    .start(start_a), .busy(a_busy), .done(a_done),
    .skipped(a_skipped), .char_data(a_data),
    .char_valid(a_valid), .char_ready(a_ready),
    .frame_count(a_fc)
  );

  board_text_serializer #(
    .ROWS(2), .COLS(4), .SPACED(0),
    .CHANGE_ONLY(0), .CNT_W(16)
  ) u_b (
    .clock(clk), .reset(rst), .board(board_b),
    .start(start_b), .busy(b_busy), .done(b_done),
    .skipped(b_skipped), .char_data(b_data),
    .char_valid(b_valid), .char_ready(b_ready),
    .frame_count(b_fc)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int         a_bytes = 0;
  int         b_bytes = 0;
  logic       a_stall = 1'b0;
  logic [7:0] a_last  = 8'h00;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] cchr(input logic [1:0] c);
    case (c)
      CELL_BLANK: return "_";
      CELL_X:     return "X";
      CELL_O:     return "O";
      default:    return "?";
    endcase
  endfunction

  function automatic logic [17:0] pk9(
    input logic [1:0] c0, c1, c2, c3, c4,
    input logic [1:0] c5, c6, c7, c8);
    return {c8, c7, c6, c5, c4, c3, c2, c1, c0};
  endfunction

  task automatic push_a(input logic [17:0] b);
    qa.push_back(8'h0A);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        qa.push_back(cchr(b[2*(r*3+c) +: 2]));
        if (c < 2) qa.push_back(8'h20);
      end
      qa.push_back(8'h0A);
    end
  endtask

  task automatic push_b(input logic [15:0] b);
    qb.push_back(8'h0A);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++)
        qb.push_back(cchr(b[2*(r*4+c) +: 2]));
      qb.push_back(8'h0A);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      a_stall = 1'b0;
    end else begin
      if (a_stall) begin
        chk("a_hold_valid", 32'(a_valid), 32'd1);
        chk("a_hold_data", 32'(a_data), 32'(a_last));
      end
      if (a_valid && a_ready) begin
        a_bytes++;
        chk("a_byte_expected", 32'(qa.size() != 0), 32'd1);
        if (qa.size() != 0)
          chk("a_byte", 32'(a_data), 32'(qa.pop_front()));
      end
      a_stall = a_valid && !a_ready;
      a_last  = a_data;
    end
  end

  always @(negedge clk) begin
    if (!rst && b_valid && b_ready) begin
      b_bytes++;
      chk("b_byte_expected", 32'(qb.size() != 0), 32'd1);
      if (qb.size() != 0)
        chk("b_byte", 32'(b_data), 32'(qb.pop_front()));
    end
  end

  // Called just after a posedge; returns just after a posedge.
  task automatic frame_a(input logic [17:0] b,
                         input bit skip,
                         input bit scramble,
                         input bit toggle,
                         input int done_at);
    bit got;
    int dk;
    got     = 1'b0;
    dk      = -1;
    board_a = b;
    a_bytes = 0;
    if (!skip) push_a(b);
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      a_ready = toggle ? (k % 4 == 0 || k % 4 == 3) : 1'b1;
      if (scramble) board_a = 18'($urandom);
      @(negedge clk);
      if (k == 0) chk("a_busy_after_start", 32'(a_busy), 32'd1);
      if (a_done) begin
        got = 1'b1;
        dk  = k;
        chk("a_skipped", 32'(a_skipped), 32'(skip));
      end
      @(posedge clk);
      #1;
    end
    a_ready = 1'b1;
    chk("a_done_seen", 32'(got), 32'd1);
    if (done_at >= 0) chk("a_done_cycle", dk, done_at);
    chk("a_queue_drained", qa.size(), 32'd0);
    chk("a_byte_count", a_bytes, skip ? 32'd0 : 32'd19);
    qa.delete();
  endtask

  logic [17:0] b1, b1o, b2;
  bit          gotb;
  int          dkb;

  initial begin
    rst     = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    a_ready = 1'b1;
    b_ready = 1'b1;
    board_a = '0;
    board_b = '0;
    b1  = pk9(CELL_X, CELL_O, CELL_BLANK,
              CELL_BLANK, CELL_X, CELL_BLANK,
              CELL_O, CELL_BLANK, CELL_X);
    b1o = pk9(CELL_X, CELL_O, CELL_BLANK,
              CELL_BLANK, CELL_O, CELL_BLANK,
              CELL_O, CELL_BLANK, CELL_X);
    b2  = pk9(CELL_O, CELL_O, CELL_X,
              CELL_X, CELL_BLANK, CELL_O,
              CELL_RSVD, CELL_X, CELL_O);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_skipped", 32'(a_skipped), 32'd0);
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_data", 32'(a_data), 32'd0);
    chk("rst_fc", 32'(a_fc), 32'd0);
    chk("rst_b_valid", 32'(b_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    frame_a(b1, 1'b0, 1'b0, 1'b0, 20);
    chk("fc_after_first", 32'(a_fc), 32'd1);
    frame_a(b2, 1'b0, 1'b1, 1'b0, 20);
    chk("fc_after_scramble", 32'(a_fc), 32'd2);
    frame_a(b1, 1'b0, 1'b0, 1'b1, -1);
    chk("fc_after_stall", 32'(a_fc), 32'd3);
    frame_a(b1, 1'b1, 1'b0, 1'b0, 1);
    chk("fc_after_skip", 32'(a_fc), 32'd3);
    frame_a(b1o, 1'b0, 1'b0, 1'b0, 20);
    chk("fc_after_change", 32'(a_fc), 32'd4);

    board_a = b2;
    a_bytes = 0;
    push_a(b2);
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    for (int k = 0; k < 100 && a_bytes < 7; k++)
      @(posedge clk);
    chk("mid_bytes", a_bytes, 32'd7);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(a_valid), 32'd0);
    chk("mid_rst_busy", 32'(a_busy), 32'd0);
    chk("mid_rst_fc", 32'(a_fc), 32'd0);
    qa.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    frame_a(b1o, 1'b0, 1'b0, 1'b0, 20);
    chk("fc_after_reset", 32'(a_fc), 32'd1);

    board_b = 16'hFFFF;
    b_bytes = 0;
    push_b(board_b);
    gotb = 1'b0;
    dkb  = -1;
    start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    for (int k = 0; k < 60 && !gotb; k++) begin
      start_b = (k == 0 || k == 2 || k == 5 || k == 12);
      @(negedge clk);
      if (b_done) begin
        gotb = 1'b1;
        dkb  = k;
        chk("b_skipped", 32'(b_skipped), 32'd0);
      end
      @(posedge clk);
      #1;
    end
    start_b = 1'b0;
    chk("b_done_seen", 32'(gotb), 32'd1);
    chk("b_done_cycle", dkb, 32'd12);
    chk("b_queue_drained", qb.size(), 32'd0);
    chk("b_byte_count", b_bytes, 32'd11);
    repeat (6) @(negedge clk);
    chk("b_idle_busy", 32'(b_busy), 32'd0);
    chk("b_no_extra", b_bytes, 32'd11);
    chk("b_fc", 32'(b_fc), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
